// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin arbiter that shares one external divider among
// NUM_REQ requesters. One request is outstanding at a time; each accepted
// request gets exactly one response, either the divider result or a timeout
// error when the divider stays silent.
//
// Handshake rules (all interfaces):
//   - A request transfers on a rising edge where req_valid[i] & req_ready[i].
//     The requester holds req_valid[i]/req_data stable until that happens.
//   - req_ready is one-hot and only ever asserted in IDLE.
//   - resp_valid and div_out_valid are single-cycle pulses with no back-pressure.
//   - div_in_valid is a single-cycle pulse from the divider; it is only
//     consumed in WAIT, anywhere else it is counted as stray.
module divider_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*64-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [63:0]            resp_data,
    output logic                   resp_err,
    output logic                   div_out_valid,
    output logic [63:0]            div_out,
    input  logic                   div_in_valid,
    input  logic [63:0]            div_in,
    output logic                   busy,
    output logic [7:0]             stray_cnt,
    output logic [1:0]             dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // Counter value at which a silent divider is declared timed out.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    // Result reported for a timed-out request: remainder 0, quotient all-ones.
    localparam logic [63:0] TMO_DATA = {32'h0000_0000, 32'hFFFF_FFFF};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] winner;
    logic             winner_found;
    int               rr_pos;

    logic [63:0]      operand_q;
    logic [63:0]      sel_data;
    logic [7:0]       tmo_cnt;

    logic             handshake;
    logic             capture;
    logic             load_ok;
    logic             load_tmo;
    logic             cnt_clr;
    logic             cnt_inc;

    // Round-robin search: first asserted req_valid starting after last_grant.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        rr_pos       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_pos = int'(last_grant) + i;
            if (rr_pos >= NUM_REQ) begin
                rr_pos = rr_pos - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!winner_found && req_valid[j] && (rr_pos == j)) begin
                    winner_found = 1'b1;
                    winner       = IDX_W'(j);
                end
            end
        end
    end

    // Operand mux for the current round-robin winner.
    always_comb begin
        sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == IDX_W'(j)) begin
                sel_data = req_data[64*j +: 64];
            end
        end
    end

    // One-hot ready to the winner, only while IDLE.
    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if ((state == IDLE) && winner_found && (winner == IDX_W'(j))) begin
                req_ready[j] = 1'b1;
            end
        end
    end

    // One-hot response pulse to the granted requester during RESP.
    always_comb begin
        resp_valid = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if ((state == RESP) && (gnt == IDX_W'(j))) begin
                resp_valid[j] = 1'b1;
            end
        end
    end

    assign handshake     = |(req_valid & req_ready);
    assign div_out_valid = (state == ISSUE);
    assign div_out       = operand_q;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and datapath control strobes.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        load_ok    = 1'b0;
        load_tmo   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    capture    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_clr    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A response arriving on the expiry cycle still wins.
                if (div_in_valid) begin
                    load_ok    = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_inc = 1'b1;
                    if ((tmo_cnt + 8'd1) == CNT_LAST) begin
                        load_tmo   = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant bookkeeping and operand capture on the accepting handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
            gnt        <= '0;
            operand_q  <= '0;
        end else if (capture) begin
            last_grant <= winner;
            gnt        <= winner;
            operand_q  <= sel_data;
        end
    end

    // Timeout counter: cleared while issuing, counts silent WAIT cycles.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tmo_cnt <= '0;
        end else if (cnt_clr) begin
            tmo_cnt <= '0;
        end else if (cnt_inc) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Response registers; held between RESP cycles.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else if (load_ok) begin
            resp_data <= div_in;
            resp_err  <= 1'b0;
        end else if (load_tmo) begin
            resp_data <= TMO_DATA;
            resp_err  <= 1'b1;
        end
    end

    // Saturating count of divider pulses that arrive outside WAIT.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stray_cnt <= '0;
        end else if (div_in_valid && (state != WAIT) && (stray_cnt != 8'hFF)) begin
            stray_cnt <= stray_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter (NUM_REQ=4, TIMEOUT=16). The divider is
// played by the stimulus itself, answering on exactly the cycles each step
// calls for.
module tb_divider_arbiter;

    logic         aclk;
    logic         aresetn;
    logic [3:0]   req_valid;
    logic [255:0] req_data;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [63:0]  resp_data;
    logic         resp_err;
    logic         div_out_valid;
    logic [63:0]  div_out;
    logic         div_in_valid;
    logic [63:0]  div_in;
    logic         busy;
    logic [7:0]   stray_cnt;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc;

    divider_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .div_out_valid (div_out_valid),
        .div_out       (div_out),
        .div_in_valid  (div_in_valid),
        .div_in        (div_in),
        .busy          (busy),
        .stray_cnt     (stray_cnt),
        .dbg_state     (dbg_state)
    );

    // Clock
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction with a 1-cycle divider; entered and left on a
    // negedge while IDLE.
    task automatic run_txn(input string tag, input logic [3:0] valid,
                           input logic [3:0] exp_ready, input logic [63:0] exp_ops,
                           input logic [63:0] result);
        req_valid = valid;
        #1;
        check({tag, ":ready"}, 64'(req_ready), 64'(exp_ready));
        tick();
        check({tag, ":issue"}, 64'(div_out_valid), 64'(1'b1));
        check({tag, ":ops"}, div_out, exp_ops);
        check({tag, ":ready_busy"}, 64'(req_ready), 64'(4'b0000));
        tick();
        check({tag, ":wait"}, 64'(dbg_state), 64'(2'd2));
        check({tag, ":issue_pulse"}, 64'(div_out_valid), 64'(1'b0));
        div_in_valid = 1'b1;
        div_in       = result;
        tick();
        div_in_valid = 1'b0;
        div_in       = '0;
        check({tag, ":resp_valid"}, 64'(resp_valid), 64'(exp_ready));
        check({tag, ":resp_data"}, resp_data, result);
        check({tag, ":resp_err"}, 64'(resp_err), 64'(1'b0));
        tick();
        check({tag, ":resp_pulse"}, 64'(resp_valid), 64'(4'b0000));
        check({tag, ":idle"}, 64'(busy), 64'(1'b0));
    endtask

    initial begin
        aresetn      = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        div_in_valid = 1'b0;
        div_in       = '0;

        // Reset state
        tick();
        tick();
        #1;
        check("rst:busy", 64'(busy), 64'(1'b0));
        check("rst:req_ready", 64'(req_ready), 64'(4'b0000));
        check("rst:resp_valid", 64'(resp_valid), 64'(4'b0000));
        check("rst:div_out_valid", 64'(div_out_valid), 64'(1'b0));
        check("rst:stray", 64'(stray_cnt), 64'(8'd0));
        check("rst:resp_data", resp_data, 64'h0);
        check("rst:resp_err", 64'(resp_err), 64'(1'b0));
        check("rst:div_out", div_out, 64'h0);
        check("rst:state", 64'(dbg_state), 64'(2'd0));
        tick();
        aresetn = 1'b1;
        tick();

        // 100 / 7 -> quotient 14, remainder 2
        req_data[63:0] = {32'd7, 32'd100};
        run_txn("div7", 4'b0001, 4'b0001, {32'd7, 32'd100}, {32'd2, 32'd14});
        req_valid = '0;
        tick();
        check("div7:held_data", resp_data, {32'd2, 32'd14});
        check("div7:no_regrant", 64'(busy), 64'(1'b0));

        // Round robin with all requesters held valid from reset
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        req_data[63:0]    = {32'd3, 32'd100};
        req_data[127:64]  = {32'd4, 32'd101};
        req_data[191:128] = {32'd5, 32'd102};
        req_data[255:192] = {32'd6, 32'd103};
        run_txn("rr0", 4'b1111, 4'b0001, {32'd3, 32'd100}, {32'd1, 32'd33});
        run_txn("rr1", 4'b1111, 4'b0010, {32'd4, 32'd101}, {32'd1, 32'd25});
        run_txn("rr2", 4'b1111, 4'b0100, {32'd5, 32'd102}, {32'd2, 32'd20});
        run_txn("rr3", 4'b1111, 4'b1000, {32'd6, 32'd103}, {32'd1, 32'd17});
        run_txn("rr4", 4'b1111, 4'b0001, {32'd3, 32'd100}, {32'd1, 32'd33});
        req_valid = '0;
        tick();

        // Divide by zero passes through as the divider reports it
        req_data[191:128] = {32'd0, 32'd55};
        run_txn("dz", 4'b0100, 4'b0100, {32'd0, 32'd55}, {32'd55, 32'hFFFF_FFFF});
        req_valid = '0;
        tick();

        // Silent divider -> timeout response 16 cycles after ISSUE
        req_data[127:64] = {32'd9, 32'd81};
        req_valid = 4'b0010;
        #1;
        check("tmo:ready", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = '0;
        check("tmo:issue", 64'(div_out_valid), 64'(1'b1));
        cyc = 0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (resp_valid != 4'b0000) break;
        end
        check("tmo:latency", 64'(cyc), 64'(16));
        check("tmo:resp_valid", 64'(resp_valid), 64'(4'b0010));
        check("tmo:resp_data", resp_data, {32'h0, 32'hFFFF_FFFF});
        check("tmo:resp_err", 64'(resp_err), 64'(1'b1));
        tick();
        check("tmo:idle", 64'(busy), 64'(1'b0));
        check("tmo:err_held", 64'(resp_err), 64'(1'b1));

        // Response on the expiry cycle is a normal response
        req_data[255:192] = {32'd4, 32'd20};
        req_valid = 4'b1000;
        #1;
        check("edge:ready", 64'(req_ready), 64'(4'b1000));
        tick();
        req_valid = '0;
        repeat (14) tick();
        tick();
        check("edge:still_wait", 64'(dbg_state), 64'(2'd2));
        div_in_valid = 1'b1;
        div_in       = {32'd0, 32'd5};
        tick();
        div_in_valid = 1'b0;
        div_in       = '0;
        check("edge:resp_valid", 64'(resp_valid), 64'(4'b1000));
        check("edge:resp_err", 64'(resp_err), 64'(1'b0));
        check("edge:resp_data", resp_data, {32'd0, 32'd5});
        tick();
        check("edge:idle", 64'(busy), 64'(1'b0));
        check("edge:stray", 64'(stray_cnt), 64'(8'd0));

        // Reset during WAIT abandons the request; late response is stray
        req_data[63:0] = {32'd3, 32'd10};
        req_valid = 4'b0001;
        #1;
        check("abort:ready", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid = '0;
        tick();
        check("abort:wait", 64'(dbg_state), 64'(2'd2));
        aresetn = 1'b0;
        #1;
        check("abort:busy", 64'(busy), 64'(1'b0));
        tick();
        aresetn      = 1'b1;
        div_in_valid = 1'b1;
        div_in       = {32'd1, 32'd3};
        tick();
        div_in_valid = 1'b0;
        div_in       = '0;
        check("abort:stray", 64'(stray_cnt), 64'(8'd1));
        check("abort:no_resp", 64'(resp_valid), 64'(4'b0000));
        check("abort:idle", 64'(busy), 64'(1'b0));
        tick();
        check("abort:no_resp_late", 64'(resp_valid), 64'(4'b0000));

        // First grant after reset goes to the lowest asserted index
        req_data[127:64] = {32'd5, 32'd17};
        run_txn("first", 4'b0110, 4'b0010, {32'd5, 32'd17}, {32'd2, 32'd3});
        req_valid = '0;
        tick();

        // 300 stray pulses in IDLE saturate the counter
        for (int n = 0; n < 253; n++) begin
            div_in_valid = 1'b1;
            tick();
            div_in_valid = 1'b0;
            tick();
        end
        check("stray:254", 64'(stray_cnt), 64'(8'd254));
        for (int n = 0; n < 47; n++) begin
            div_in_valid = 1'b1;
            tick();
            div_in_valid = 1'b0;
            tick();
        end
        check("stray:sat", 64'(stray_cnt), 64'(8'd255));
        check("stray:state", 64'(dbg_state), 64'(2'd0));
        check("stray:busy", 64'(busy), 64'(1'b0));
        check("stray:no_resp", 64'(resp_valid), 64'(4'b0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
